// File: rtl/mfp_ahb_lite_master_arbiter_if.sv
// mfp_ahb_lite_master_arbiter_if: one AHB-Lite master<->slave link (address/control, write data, read data, ready, response).
interface mfp_ahb_lite_master_arbiter_if;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    modport master (
        output haddr, hburst, hmastlock, hprot, hsize, htrans, hwdata, hwrite,
        input  hrdata, hready, hresp
    );
    modport slave (
        input  haddr, hburst, hmastlock, hprot, hsize, htrans, hwdata, hwrite,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/mfp_ahb_lite_master_arbiter.sv
// mfp_ahb_lite_master_arbiter: shares one AHB-Lite slave port between the core (m0) and the loader (m1),
// handing ownership over only at an idle, unlocked boundary of the current owner.
module mfp_ahb_lite_master_arbiter #(
    parameter bit DEFAULT_OWNER = 1'b0,
    parameter int STARVE_LIMIT  = 1023
) (
    input  logic                          HCLK,
    input  logic                          SI_Reset,
    mfp_ahb_lite_master_arbiter_if.slave  m0,
    mfp_ahb_lite_master_arbiter_if.slave  m1,
    mfp_ahb_lite_master_arbiter_if.master s,
    output logic                          Owner,
    output logic                          Starve
);
    localparam int W = $clog2(STARVE_LIMIT + 1);

    logic         addr_owner;
    logic         data_owner;
    logic [W-1:0] wait_cnt;
    logic [1:0]   own_trans;
    logic         own_lock;
    logic         other_req;
    logic         sw;

    assign own_trans = addr_owner ? m1.htrans : m0.htrans;
    assign own_lock  = addr_owner ? m1.hmastlock : m0.hmastlock;
    assign other_req = addr_owner ? m0.htrans[1] : m1.htrans[1];
    assign sw        = s.hready && own_trans == 2'b00 && !own_lock && other_req;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            addr_owner <= DEFAULT_OWNER;
            data_owner <= DEFAULT_OWNER;
            wait_cnt   <= '0;
        end else begin
            if (sw)
                addr_owner <= ~addr_owner;
            if (s.hready)
                data_owner <= addr_owner;
            wait_cnt <= (sw || !other_req) ? '0 :
                        (wait_cnt == W'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    assign Owner  = addr_owner;
    assign Starve = wait_cnt == W'(STARVE_LIMIT);

    assign s.haddr     = addr_owner ? m1.haddr     : m0.haddr;
    assign s.hburst    = addr_owner ? m1.hburst    : m0.hburst;
    assign s.hmastlock = addr_owner ? m1.hmastlock : m0.hmastlock;
    assign s.hprot     = addr_owner ? m1.hprot     : m0.hprot;
    assign s.hsize     = addr_owner ? m1.hsize     : m0.hsize;
    assign s.htrans    = addr_owner ? m1.htrans    : m0.htrans;
    assign s.hwrite    = addr_owner ? m1.hwrite    : m0.hwrite;
    assign s.hwdata    = data_owner ? m1.hwdata    : m0.hwdata;

    // the stalled master sees HREADY low so it keeps its request stable
    assign m0.hready = !addr_owner && s.hready;
    assign m1.hready =  addr_owner && s.hready;
    assign m0.hresp  = !data_owner && s.hresp;
    assign m1.hresp  =  data_owner && s.hresp;
    assign m0.hrdata = s.hrdata;
    assign m1.hrdata = s.hrdata;
endmodule

// File: tb/tb_mfp_ahb_lite_master_arbiter.sv
// tb_mfp_ahb_lite_master_arbiter: directed scenarios for the two-master arbiter with STARVE_LIMIT=15.
module tb_mfp_ahb_lite_master_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic owner;
    logic starve;
    int   checks = 0;
    int   failures = 0;

    mfp_ahb_lite_master_arbiter_if m0_bus ();
    mfp_ahb_lite_master_arbiter_if m1_bus ();
    mfp_ahb_lite_master_arbiter_if s_bus ();

    mfp_ahb_lite_master_arbiter #(.DEFAULT_OWNER(1'b0), .STARVE_LIMIT(15)) dut (
        .HCLK(clk), .SI_Reset(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .Owner(owner), .Starve(starve)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic m0_drive(input logic [1:0] t, input logic [31:0] a, input logic lk);
        m0_bus.htrans = t; m0_bus.haddr = a; m0_bus.hmastlock = lk;
    endtask

    task automatic m1_drive(input logic [1:0] t, input logic [31:0] a, input logic lk);
        m1_bus.htrans = t; m1_bus.haddr = a; m1_bus.hmastlock = lk;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_bus.hready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%0b exp=0", owner); end
        checks++; if (s_bus.htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%0b exp=00", s_bus.htrans); end
        checks++; if (m1_bus.hready !== 1'b0) begin failures++; $display("FAIL reset_m1_hready got=%0b exp=0", m1_bus.hready); end
        checks++; if (m0_bus.hready !== 1'b1) begin failures++; $display("FAIL reset_m0_hready_hi got=%0b exp=1", m0_bus.hready); end
        checks++; if (starve !== 1'b0) begin failures++; $display("FAIL reset_starve got=%0b exp=0", starve); end
        s_bus.hready = 1'b0;
        #1;
        checks++; if (m0_bus.hready !== 1'b0) begin failures++; $display("FAIL reset_m0_hready_lo got=%0b exp=0", m0_bus.hready); end
        s_bus.hready = 1'b1;
    endtask

    task automatic test_m1_write;
        m1_drive(2'b10, 32'h1F80_0000, 1'b0);
        m1_bus.hwrite = 1'b1;
        #1;
        checks++; if (m1_bus.hready !== 1'b0) begin failures++; $display("FAIL wr_m1_stalled got=%0b exp=0", m1_bus.hready); end
        tick();
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL wr_owner got=%0b exp=1", owner); end
        checks++; if (s_bus.haddr !== 32'h1F80_0000) begin failures++; $display("FAIL wr_haddr got=%h exp=1f800000", s_bus.haddr); end
        checks++; if (s_bus.hwrite !== 1'b1) begin failures++; $display("FAIL wr_hwrite got=%0b exp=1", s_bus.hwrite); end
        checks++; if (m1_bus.hready !== 1'b1) begin failures++; $display("FAIL wr_m1_hready got=%0b exp=1", m1_bus.hready); end
        tick();
        m1_drive(2'b00, 32'h0, 1'b0);
        m1_bus.hwrite = 1'b0;
        m1_bus.hwdata = 32'hDEAD_BEEF;
        s_bus.hresp = 1'b1;
        #1;
        checks++; if (s_bus.hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hwdata got=%h exp=deadbeef", s_bus.hwdata); end
        checks++; if (m1_bus.hresp !== 1'b1 || m0_bus.hresp !== 1'b0) begin failures++; $display("FAIL wr_hresp got=%0b%0b exp=10", m1_bus.hresp, m0_bus.hresp); end
        checks++; if (m0_bus.hready !== 1'b0) begin failures++; $display("FAIL wr_m0_stalled got=%0b exp=0", m0_bus.hready); end
        s_bus.hresp = 1'b0;
        tick();
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL wr_park got=%0b exp=1", owner); end
    endtask

    task automatic test_burst;
        m0_drive(2'b10, 32'h100, 1'b0);
        m0_bus.hburst = 3'b011;
        tick();
        checks++; if (owner !== 1'b0 || s_bus.haddr !== 32'h100) begin failures++; $display("FAIL burst_start got=%0b/%h exp=0/00000100", owner, s_bus.haddr); end
        for (int i = 1; i < 4; i++) begin
            tick();
            m0_drive(2'b11, 32'h100 + 32'(4 * i), 1'b0);
            m1_drive(2'b10, 32'h200, 1'b0);
            #1;
            checks++; if (owner !== 1'b0 || s_bus.htrans !== 2'b11 || s_bus.haddr !== 32'h100 + 32'(4 * i)) begin
                failures++; $display("FAIL burst_beat%0d got=%0b/%b/%h", i, owner, s_bus.htrans, s_bus.haddr);
            end
            checks++; if (m1_bus.hready !== 1'b0) begin failures++; $display("FAIL burst_m1_hready%0d got=%0b exp=0", i, m1_bus.hready); end
        end
        tick();
        m0_drive(2'b00, 32'h0, 1'b0);
        m0_bus.hburst = 3'b000;
        #1;
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL burst_hold got=%0b exp=0", owner); end
        tick();
        checks++; if (owner !== 1'b1 || s_bus.haddr !== 32'h200) begin failures++; $display("FAIL burst_switch got=%0b/%h exp=1/00000200", owner, s_bus.haddr); end
        tick();
        m1_drive(2'b00, 32'h0, 1'b0);
        m0_drive(2'b10, 32'h300, 1'b0);
        tick();
        checks++; if (owner !== 1'b0 || s_bus.haddr !== 32'h300) begin failures++; $display("FAIL burst_return got=%0b/%h exp=0/00000300", owner, s_bus.haddr); end
        tick();
        m0_drive(2'b00, 32'h0, 1'b0);
        m0_bus.hwdata = 32'hA0A0_A0A0;
    endtask

    task automatic test_wait_states;
        s_bus.hready = 1'b0;
        m1_drive(2'b10, 32'h400, 1'b0);
        m1_bus.hwdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            s_bus.hresp = 1'b1;
            #1;
            checks++; if (owner !== 1'b0) begin failures++; $display("FAIL ws_owner%0d got=%0b exp=0", i, owner); end
            checks++; if (s_bus.hwdata !== 32'hA0A0_A0A0) begin failures++; $display("FAIL ws_hwdata%0d got=%h exp=a0a0a0a0", i, s_bus.hwdata); end
            checks++; if (m0_bus.hresp !== 1'b1 || m1_bus.hresp !== 1'b0) begin failures++; $display("FAIL ws_hresp%0d got=%0b%0b exp=10", i, m0_bus.hresp, m1_bus.hresp); end
        end
        s_bus.hresp = 1'b0;
        s_bus.hready = 1'b1;
        tick();
        checks++; if (owner !== 1'b1 || s_bus.hwdata !== 32'hA0A0_A0A0) begin failures++; $display("FAIL ws_switch got=%0b/%h exp=1/a0a0a0a0", owner, s_bus.hwdata); end
        tick();
        m1_drive(2'b00, 32'h0, 1'b0);
        #1;
        checks++; if (s_bus.hwdata !== 32'h1111_1111) begin failures++; $display("FAIL ws_m1_data got=%h exp=11111111", s_bus.hwdata); end
    endtask

    task automatic test_lock;
        m0_drive(2'b10, 32'h500, 1'b1);
        tick();
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL lock_take got=%0b exp=0", owner); end
        m0_drive(2'b00, 32'h0, 1'b1);
        m1_drive(2'b10, 32'h600, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (owner !== 1'b0) begin failures++; $display("FAIL lock_hold%0d got=%0b exp=0", i, owner); end
        end
        m0_drive(2'b00, 32'h0, 1'b0);
        tick();
        checks++; if (owner !== 1'b1 || s_bus.haddr !== 32'h600) begin failures++; $display("FAIL lock_release got=%0b/%h exp=1/00000600", owner, s_bus.haddr); end
        tick();
        m1_drive(2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_starve;
        m0_drive(2'b10, 32'h700, 1'b0);
        m0_bus.hburst = 3'b001;
        tick();
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL starve_take got=%0b exp=0", owner); end
        m0_drive(2'b11, 32'h704, 1'b0);
        m1_drive(2'b10, 32'h800, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (starve !== (i == 15) || owner !== 1'b0) begin
                failures++; $display("FAIL starve_cnt%0d got=%0b/%0b exp=%0b/0", i, starve, owner, i == 15);
            end
        end
        tick();
        checks++; if (starve !== 1'b1) begin failures++; $display("FAIL starve_sat got=%0b exp=1", starve); end
        m0_drive(2'b00, 32'h0, 1'b0);
        m0_bus.hburst = 3'b000;
        tick();
        checks++; if (owner !== 1'b1 || starve !== 1'b0) begin failures++; $display("FAIL starve_clear got=%0b/%0b exp=1/0", owner, starve); end
        m1_drive(2'b11, 32'h804, 1'b0);
        m0_drive(2'b10, 32'h900, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (owner !== 1'b0 || starve !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0b/%0b exp=0/0", owner, starve); end
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (starve !== (i == 15) || owner !== 1'b0) begin
                failures++; $display("FAIL rst_recount%0d got=%0b/%0b exp=%0b/0", i, starve, owner, i == 15);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_drive(2'b00, 32'h0, 1'b0);
        m1_drive(2'b00, 32'h0, 1'b0);
        m0_bus.hburst = 3'b000; m0_bus.hprot = 4'h3; m0_bus.hsize = 3'b010; m0_bus.hwrite = 1'b0; m0_bus.hwdata = 32'h0;
        m1_bus.hburst = 3'b000; m1_bus.hprot = 4'h3; m1_bus.hsize = 3'b010; m1_bus.hwrite = 1'b0; m1_bus.hwdata = 32'h0;
        s_bus.hrdata = 32'h5A5A_1234; s_bus.hready = 1'b1; s_bus.hresp = 1'b0;
        test_reset();
        checks++; if (m0_bus.hrdata !== 32'h5A5A_1234 || m1_bus.hrdata !== 32'h5A5A_1234) begin
            failures++; $display("FAIL hrdata_bcast got=%h/%h exp=5a5a1234", m0_bus.hrdata, m1_bus.hrdata);
        end
        test_m1_write();
        test_burst();
        test_wait_states();
        test_lock();
        test_starve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mfp_ahb_lite_master_arbiter.md
Name: mfp_ahb_lite_master_arbiter

Overview:
- Two-master to one-slave AHB-Lite bus arbiter. It shares the AHB-Lite matrix between the m14k core (master 0) and the serial/UART program loader (master 1).
- Sits between both masters and the matrix slave port, and muxes address, control and write data by ownership.
- Stalls the non-owning master through its HREADY. No transfer is ever pre-empted, replayed or split.
- Ownership changes only on a bus-idle boundary of the current owner.

Parameters:
- DEFAULT_OWNER, 0, owner after reset and park owner (0 = core, 1 = loader).
- STARVE_LIMIT, 1023, stall-cycle count at which Starve asserts; counter width is clog2(STARVE_LIMIT+1).

Ports:
- HCLK  in  1  bus clock, rising edge.
- SI_Reset  in  1  synchronous, active-high reset.
- M0_HADDR, M1_HADDR  in  32  master address.
- M0_HBURST, M1_HBURST  in  3  burst type.
- M0_HMASTLOCK, M1_HMASTLOCK  in  1  locked-sequence flag.
- M0_HPROT, M1_HPROT  in  4  protection control.
- M0_HSIZE, M1_HSIZE  in  3  transfer size.
- M0_HTRANS, M1_HTRANS  in  2  transfer type.
- M0_HWDATA, M1_HWDATA  in  32  write data.
- M0_HWRITE, M1_HWRITE  in  1  write flag.
- M0_HRDATA, M1_HRDATA  out  32  read data (broadcast of S_HRDATA).
- M0_HREADY, M1_HREADY  out  1  per-master ready.
- M0_HRESP, M1_HRESP  out  1  per-master response.
- S_HADDR, S_HBURST, S_HMASTLOCK, S_HPROT, S_HSIZE, S_HTRANS, S_HWDATA, S_HWRITE  out  as master  to matrix.
- S_HRDATA  in  32  from matrix.
- S_HREADY  in  1  from matrix.
- S_HRESP  in  1  from matrix.
- Owner  out  1  current address-phase owner.
- Starve  out  1  waiting master stalled for at least STARVE_LIMIT cycles.

Behaviour:
- State registers:
  - addr_owner: drives Owner.
  - data_owner: owner of the current data phase.
  - wait_cnt: saturating counter.
  - All reset to DEFAULT_OWNER, DEFAULT_OWNER and 0 on a SI_Reset=1 clock edge.
  - Reset mid-transfer aborts ownership history; no outputs are held.
- Address/control mux: S_* address and control = addr_owner's inputs, combinational, zero latency.
- Write-data mux: S_HWDATA = data_owner's HWDATA.
- Data-phase tracking: every edge with S_HREADY=1 performs data_owner <= addr_owner. With S_HREADY=0, data_owner holds.
- Request definition: Mx requests when Mx_HTRANS[1]=1 (NONSEQ or SEQ).
- Switch condition: at an edge, addr_owner <= other master only when all of the following hold:
  - S_HREADY=1;
  - the owner's HTRANS = IDLE (2'b00);
  - the owner's HMASTLOCK=0;
  - the other master is requesting.
  Otherwise addr_owner holds.
- No switch is ever made while the owner presents NONSEQ, SEQ or BUSY, or has lock asserted. Bursts and locked sequences are therefore never broken.
- Parking: when neither master requests, ownership is unchanged.
- HREADY routing:
  - Mx_HREADY = S_HREADY if x == addr_owner.
  - Otherwise Mx_HREADY = 0, so the waiting master holds its address and control stable.
  - The non-owner's previous data phase is always an IDLE data phase, so forcing its HREADY to 0 never corrupts a transfer.
- HRESP routing: Mx_HRESP = S_HRESP if x == data_owner, else 0.
- Read data: M0_HRDATA = M1_HRDATA = S_HRDATA.
- Switch latency: the waiting master's held NONSEQ appears on S_HADDR in the cycle after the switch edge. That cycle's S_HREADY completes its address phase.
- ERROR response:
  - In the first ERROR cycle (S_HREADY=0) no switch occurs.
  - If the owner drives IDLE and the second ERROR cycle has S_HREADY=1, a switch may occur at that edge.
- Starve counter:
  - wait_cnt increments each cycle the non-owner requests.
  - It clears on a switch or when the non-owner is not requesting.
  - It saturates at STARVE_LIMIT.
  - Starve = (wait_cnt == STARVE_LIMIT), registered.
- Simultaneous requests from both masters while the owner is IDLE cannot occur: an owner presenting IDLE is by definition not requesting. The non-owner's request always wins the next idle boundary.

Test Plan:
- Reset with DEFAULT_OWNER=0, both masters IDLE:
  - Owner=0, S_HTRANS=00, M1_HREADY=0, M0_HREADY follows S_HREADY, Starve=0.
- M1 NONSEQ write to 0x1F800000 while M0 idles:
  - Switch edge, then S_HADDR=0x1F800000 next cycle.
  - M1_HREADY=1 releases the address phase.
  - M1_HWDATA=0xDEADBEEF appears on S_HWDATA in the following cycle.
- M0 INCR4 burst with M1 requesting in beat 2:
  - All 4 beats (NONSEQ, SEQ, SEQ, SEQ) are issued by M0.
  - Owner switches only after M0 drives IDLE.
  - M1_HREADY=0 throughout the burst.
- Slave inserts 3 wait states (S_HREADY=0) while owner M0 is IDLE and M1 requests:
  - No switch until the edge where S_HREADY=1.
  - data_owner stays 0 and the HRESP/HWDATA routing stays on M0.
- Locked sequence, M0_HMASTLOCK=1 with IDLE between transfers, M1 requesting: no switch until lock is deasserted.
- STARVE_LIMIT=15, M0 continuous SEQ traffic, M1 requesting:
  - Starve=1 after 15 stall cycles.
  - Starve clears the cycle after the switch.
  - SI_Reset pulse mid-burst returns Owner=0 and wait_cnt=0.
